pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: number of consecutive cycles the synchronized lock must stay high before the hold phase starts (minimum 1).
REQ-002 Parameter HOLD_CYCLES, default 16: number of cycles the reset stays asserted after stability, and the minimum fault duration (minimum 1).
REQ-003 Parameter CNT_W, default 8: width of loss_count.
REQ-004 Port clock, in, 1: single clock, the PLL output clock; all logic is on its rising edge.
REQ-005 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-006 Port lock_in, in, 1: raw PLL lock; asynchronous to clock.
REQ-007 Port force, in, 1: synchronous request to re-run the reset sequence.
REQ-008 Port reset_out, out, 1: active-high reset for downstream logic.
REQ-009 Port ready, out, 1: high only in RUN; always the inverse of reset_out.
REQ-010 Port lost, out, 1: one-cycle pulse when lock is lost while in RUN.
REQ-011 Port loss_count, out, CNT_W: saturating count of lock losses seen in RUN.

Function
REQ-012 lock_in SHALL pass through a 2-flop synchronizer, giving lock_s with 2 cycles of latency; no other logic uses lock_in directly.
REQ-013 The FSM SHALL have exactly these states: IDLE, STABLE, HOLD, RUN, FAULT.
REQ-014 IDLE: if lock_s=1, go to STABLE and set cnt=0.
REQ-015 STABLE: if lock_s=0, go to IDLE; else if cnt==STABLE_CYCLES-1, go to HOLD and set cnt=0; else increment cnt.
REQ-016 HOLD: if lock_s=0, go to IDLE (loss_count unchanged); else if cnt==HOLD_CYCLES-1, go to RUN; else increment cnt.
REQ-017 RUN, lock_s=0: go to FAULT, set cnt=0, pulse lost for 1 cycle, and increment loss_count unless it equals all-ones.
REQ-018 RUN, lock_s=1 and force=1: go to FAULT with cnt=0; no lost pulse and no count.
REQ-019 RUN, lock_s=0 and force=1 in the same cycle: treated as lock loss (REQ-017).
REQ-020 FAULT: stay HOLD_CYCLES cycles regardless of lock_s, then go to IDLE.
REQ-021 force is ignored in every state other than RUN.
REQ-022 reset_out, ready and lost SHALL be registered (driven directly by flops); reset_out=0 exactly when the state is RUN.
REQ-023 Latency: lock_in rising and held high -> reset_out falls after 3+STABLE_CYCLES+HOLD_CYCLES rising edges.
REQ-024 cnt width SHALL be clog2 of max(STABLE_CYCLES, HOLD_CYCLES), with a minimum of 1 bit.

Reset
REQ-025 While reset_n=0: state=IDLE, synchronizer flops=0, cnt=0, reset_out=1, ready=0, lost=0, loss_count=0; asserted asynchronously.
REQ-026 Deassertion of reset_n SHALL be synchronized internally (2-flop release) so FSM exit from reset is glitch-free.
REQ-027 reset_n asserted mid-sequence, including in RUN, SHALL NOT pulse lost or change loss_count other than clearing it.

Structure
REQ-028 The state encoding (IDLE, STABLE, HOLD, RUN, FAULT) and the default parameter values SHALL live in a shared package, pll_pkg.
REQ-029 One sub-module, sync2 (generic 2-flop synchronizer), SHALL be used both for lock_in and for the reset_n release.
REQ-030 All other logic SHALL be a single FSM process plus output registers.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2)
REQ-031 reset_n released, lock_in high from cycle 0 -> reset_out=1 through edge 14, reset_out=0 and ready=1 after edge 15.
REQ-032 Lock glitch: lock_in low for 3 cycles during STABLE -> return to IDLE, counter restarts, total latency measured from the last rise is 15 edges.
REQ-033 Lock drop in RUN -> lost=1 for exactly 1 cycle, loss_count 0->1, reset_out=1 for ≥4 cycles, then re-sequence when lock returns.
REQ-034 Four lock losses in RUN -> loss_count reads 3 (saturated), and lost still pulses 4 times.
REQ-035 force=1 in RUN -> FAULT for 4 cycles, lost=0, loss_count unchanged; force=1 during HOLD -> no effect.
REQ-036 reset_n asserted in RUN -> reset_out=1 and loss_count=0 immediately (asynchronous), no lost pulse.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding,
// default parameter values and the counter-width helper.
package pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STABLE = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } pll_state_t;

  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int HOLD_CYCLES_DEF   = 16;
  localparam int CNT_W_DEF         = 8;

  // Width of the phase counter: enough to reach the longer of the two
  // phase lengths minus one, never less than one bit.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int longest;
    longest = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    if (longest <= 1) begin
      return 1;
    end else begin
      return $clog2(longest);
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of an asynchronous level into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: waits for a stable lock, holds reset a little
// longer, then releases downstream logic; re-sequences on lock loss or
// on a request from the system.
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             lock_in,
  input  logic             force_req,
  output logic             reset_out,
  output logic             ready,
  output logic             lost,
  output logic [CNT_W-1:0] loss_count
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  logic             rst_sync_n_s;
  logic             lock_s;
  pll_state_t       state_r;
  pll_state_t       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx_s;
  logic             lost_nx_s;
  logic             count_inc_s;
  logic             reset_out_r;
  logic             ready_r;
  logic             lost_r;
  logic [CNT_W-1:0] loss_count_r;

  // Reset assertion is immediate; release is delayed two clocks so the
  // FSM leaves reset cleanly. The lock path runs on the raw reset so its
  // pipeline is already filling while the FSM is still held.
  sync2 u_rst_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (1'b1),
    .q       (rst_sync_n_s)
  );

  sync2 u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (lock_in),
    .q       (lock_s)
  );

  // State and phase counter registers.
  always_ff @(posedge clock or negedge rst_sync_n_s) begin
    if (!rst_sync_n_s) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state, counter and event decode.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    lost_nx_s   = 1'b0;
    count_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lock_s) begin
          state_nx_s = ST_STABLE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == STABLE_LAST) begin
          state_nx_s = ST_HOLD;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CW'(1'b1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == HOLD_LAST) begin
          state_nx_s = ST_RUN;
        end else begin
          cnt_nx_s = cnt_r + CW'(1'b1);
        end
      end
      ST_RUN: begin
        // A lock loss wins over a simultaneous re-run request.
        if (!lock_s) begin
          state_nx_s  = ST_FAULT;
          cnt_nx_s    = {CW{1'b0}};
          lost_nx_s   = 1'b1;
          count_inc_s = 1'b1;
        end else if (force_req) begin
          state_nx_s = ST_FAULT;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (cnt_r == HOLD_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output flops, loaded from the next state so they track the FSM
  // without an extra cycle of lag.
  always_ff @(posedge clock or negedge rst_sync_n_s) begin
    if (!rst_sync_n_s) begin
      reset_out_r  <= 1'b1;
      ready_r      <= 1'b0;
      lost_r       <= 1'b0;
      loss_count_r <= {CNT_W{1'b0}};
    end else begin
      reset_out_r <= (state_nx_s != ST_RUN);
      ready_r     <= (state_nx_s == ST_RUN);
      lost_r      <= lost_nx_s;
      if (count_inc_s && (loss_count_r != {CNT_W{1'b1}})) begin
        loss_count_r <= loss_count_r + CNT_W'(1'b1);
      end
    end
  end

  assign reset_out  = reset_out_r;
  assign ready      = ready_r;
  assign lost       = lost_r;
  assign loss_count = loss_count_r;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short phases: directed latency, glitch,
// saturation, re-run and reset scenarios, then randomized lock traffic.
module tb_pll_reset_seq;

  localparam int S  = 8;
  localparam int H  = 4;
  localparam int CW = 2;

  logic          clock;
  logic          reset_n;
  logic          lock_in;
  logic          force_req;
  logic          reset_out;
  logic          ready;
  logic          lost;
  logic [CW-1:0] loss_count;

  int n_cmp;
  int n_mis;

  // Reference model: lock pipeline plus "consecutive lock" streak,
  // a running flag and a fault countdown.
  logic m_pipe0, m_pipe1;
  logic m_in_run;
  int   m_fault_left;
  int   m_streak;
  int   m_hold;
  logic m_lost;
  int   m_count;

  pll_reset_seq #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .CNT_W         (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .lock_in    (lock_in),
    .force_req  (force_req),
    .reset_out  (reset_out),
    .ready      (ready),
    .lost       (lost),
    .loss_count (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pipe0      = 1'b0;
    m_pipe1      = 1'b0;
    m_in_run     = 1'b0;
    m_fault_left = 0;
    m_streak     = 0;
    m_hold       = 0;
    m_lost       = 1'b0;
    m_count      = 0;
  endtask

  // One rising edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    logic seen;
    if (!reset_n) begin
      model_clear();
    end else begin
      seen    = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = lock_in;
      m_lost  = 1'b0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (m_in_run) begin
        if (!seen) begin
          m_lost       = 1'b1;
          m_in_run     = 1'b0;
          m_fault_left = H;
          if (m_count < (1 << CW) - 1) m_count++;
        end else if (force_req) begin
          m_in_run     = 1'b0;
          m_fault_left = H;
        end
      end else if (m_fault_left > 0) begin
        m_fault_left--;
        m_streak = 0;
      end else begin
        // One idle edge, S stable edges and H hold edges of unbroken lock.
        m_streak = seen ? m_streak + 1 : 0;
        if (m_streak == S + H + 1) begin
          m_in_run = 1'b1;
          m_streak = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("reset_out", {31'd0, reset_out}, {31'd0, ~m_in_run});
    check_eq("ready", {31'd0, ready}, {31'd0, m_in_run});
    check_eq("lost", {31'd0, lost}, {31'd0, m_lost});
    check_eq("loss_count", {30'd0, loss_count}, m_count);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_reset_out", {31'd0, reset_out}, 32'd1);
    check_eq("rst_lost", {31'd0, lost}, 32'd0);
    check_eq("rst_loss_count", {30'd0, loss_count}, 32'd0);
    check_outputs();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    m_hold  = 2;
  endtask

  initial begin
    int pulses;
    n_cmp     = 0;
    n_mis     = 0;
    reset_n   = 1'b0;
    lock_in   = 1'b0;
    force_req = 1'b0;
    model_clear();
    @(posedge clock);
    #1;

    // Lock high from release: reset_out drops after edge 15.
    lock_in = 1'b1;
    assert_reset();
    tick();
    tick();
    release_reset();
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 14) check_eq("lat_e14_reset_out", {31'd0, reset_out}, 32'd1);
      if (e == 15) begin
        check_eq("lat_e15_reset_out", {31'd0, reset_out}, 32'd0);
        check_eq("lat_e15_ready", {31'd0, ready}, 32'd1);
      end
    end

    // Glitch during STABLE, then force during HOLD which must be ignored.
    assert_reset();
    tick();
    release_reset();
    for (int e = 0; e < 6; e++) tick();
    lock_in = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    lock_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 10) force_req = 1'b1;
      if (e == 14) begin
        check_eq("glitch_e14_reset_out", {31'd0, reset_out}, 32'd1);
        force_req = 1'b0;
      end
      if (e == 15) check_eq("glitch_e15_reset_out", {31'd0, reset_out}, 32'd0);
    end

    // Four losses in RUN: count saturates at 3, four lost pulses.
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      lock_in = 1'b0;
      for (int e = 0; e < 3; e++) begin
        tick();
        if (lost) pulses++;
      end
      check_eq("loss_reset_out", {31'd0, reset_out}, 32'd1);
      lock_in = 1'b1;
      for (int e = 0; e < 30; e++) begin
        tick();
        if (lost) pulses++;
      end
      if (k == 0) check_eq("loss_first_count", {30'd0, loss_count}, 32'd1);
    end
    check_eq("sat_count", {30'd0, loss_count}, 32'd3);
    check_eq("sat_pulses", pulses, 32'd4);

    // Re-run request in RUN: reset reasserts, no lost, count unchanged.
    force_req = 1'b1;
    tick();
    force_req = 1'b0;
    check_eq("force_reset_out", {31'd0, reset_out}, 32'd1);
    pulses = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (lost) pulses++;
    end
    check_eq("force_no_lost", pulses, 32'd0);
    check_eq("force_count", {30'd0, loss_count}, 32'd3);
    check_eq("force_back_run", {31'd0, ready}, 32'd1);

    // Reset while in RUN clears immediately.
    assert_reset();
    tick();
    tick();
    release_reset();

    // Randomized lock traffic with sporadic re-run requests and resets.
    for (int seg = 0; seg < 60; seg++) begin
      int hi_len;
      int lo_len;
      hi_len  = $urandom_range(5, 40);
      lo_len  = $urandom_range(1, 6);
      lock_in = 1'b1;
      for (int e = 0; e < hi_len; e++) begin
        force_req = ($urandom_range(0, 15) == 0);
        tick();
      end
      force_req = 1'b0;
      lock_in   = 1'b0;
      for (int e = 0; e < lo_len; e++) begin
        force_req = ($urandom_range(0, 3) == 0);
        tick();
      end
      force_req = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        assert_reset();
        for (int e = 0; e < $urandom_range(1, 3); e++) tick();
        release_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
